// File: rtl/keyrom_ctrl_pkg.sv
// Shared types and helpers for the key-ROM read sequencer.
// Holds the FSM state encoding, port IDs and word-count helper.
package keyrom_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    RD,
    CAP,
    OUT,
    FIN
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  function automatic int keyrom_nw(input int mem_size);
    return mem_size / 2;
  endfunction

endpackage

// File: rtl/keyrom_rr_arb.sv
// Two-input round-robin arbiter for the key-ROM sequencer.
// Priority flips to the other port when a granted burst finishes.
module keyrom_rr_arb
  import keyrom_ctrl_pkg::*;
(
  input  logic       mclk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       take,
  input  logic       fin,
  output logic [1:0] gnt
);

  logic prio_q;
  logic owner_q;

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || prio_q == PORT_A))
      gnt[0] = 1'b1;
    else if (req[1])
      gnt[1] = 1'b1;
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q  <= PORT_A;
      owner_q <= PORT_A;
    end else begin
      if (take)
        owner_q <= gnt[1];
      if (fin)
        prio_q <= ~owner_q;
    end
  end

endmodule

// File: rtl/keyrom_ctrl.sv
// Read sequencer and two-port arbiter for the secret-key ROM.
// Define KEYROM_CTRL_LOCK_EN to add the sticky lock_set/locked feature.
module keyrom_ctrl
  import keyrom_ctrl_pkg::*;
#(
  parameter int ADDR_MSB = 4,
  parameter int MEM_SIZE = 20
) (
  input  logic              mclk,
  input  logic              reset_n,
  input  logic              key_gate,
  input  logic              a_req,
  input  logic              b_req,
  input  logic [ADDR_MSB:0] a_base,
  input  logic [ADDR_MSB:0] b_base,
  input  logic [ADDR_MSB+1:0] a_len,
  input  logic [ADDR_MSB+1:0] b_len,
  output logic              a_valid,
  output logic              b_valid,
  input  logic              a_ready,
  input  logic              b_ready,
  output logic              a_done,
  output logic              b_done,
  output logic              a_err,
  output logic              b_err,
  output logic [15:0]       key_data,
  output logic [ADDR_MSB:0] rom_addr,
  output logic              rom_cen,
  input  logic [15:0]       rom_dout
`ifdef KEYROM_CTRL_LOCK_EN
  ,
  input  logic              lock_set,
  output logic              locked
`endif
);

  localparam int AW = ADDR_MSB + 1;
  localparam int LW = ADDR_MSB + 2;
  localparam int SW = ADDR_MSB + 3;
  localparam int NW = keyrom_nw(MEM_SIZE);

  state_t          state_q, state_d;
  logic            port_q, port_d;
  logic [AW-1:0]   base_q, base_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic [15:0]     kd_q, kd_d;
  logic            err_q, err_d;

  logic [1:0]      gnt;
  logic            take;
  logic            lock_act;
  logic            over;
  logic            rd_go;
  logic            out_v;
  logic            rdy_sel;
  logic [SW-1:0]   end_s;
  logic [LW-1:0]   cnt_inc;

`ifdef KEYROM_CTRL_LOCK_EN
  logic locked_q;

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n)
      locked_q <= 1'b0;
    else if (lock_set)
      locked_q <= 1'b1;
  end

  assign locked   = locked_q;
  assign lock_act = locked_q;
`else
  assign lock_act = 1'b0;
`endif

  assign take = (state_q == IDLE) && (|gnt);

  keyrom_rr_arb u_arb (
    .mclk    (mclk),
    .reset_n (reset_n),
    .req     ({b_req, a_req}),
    .take    (take),
    .fin     (state_q == FIN),
    .gnt     (gnt)
  );

  // Bounds sum carries an extra bit so base+len can never wrap.
  assign end_s   = SW'(base_q) + SW'(len_q);
  assign over    = end_s > SW'(NW);
  assign cnt_inc = cnt_q + LW'(1);
  assign rdy_sel = (port_q == PORT_B) ? b_ready : a_ready;

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    kd_d    = kd_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          port_d  = gnt[1] ? PORT_B : PORT_A;
          base_d  = gnt[1] ? b_base : a_base;
          len_d   = gnt[1] ? b_len : a_len;
          err_d   = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!key_gate || over || lock_act) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else if (len_q == '0) begin
          state_d = FIN;
        end else begin
          cnt_d   = '0;
          state_d = RD;
        end
      end
      RD: begin
        if (!key_gate || lock_act) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          state_d = CAP;
        end
      end
      CAP: begin
        kd_d    = rom_dout;
        state_d = OUT;
      end
      OUT: begin
        if (!key_gate) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else if (rdy_sel) begin
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == len_q) ? FIN : RD;
        end
      end
      FIN: begin
        kd_d    = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // No key residue survives into the completion cycle.
    if (state_d == FIN)
      kd_d = '0;
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      port_q  <= PORT_A;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      kd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      kd_q    <= kd_d;
      err_q   <= err_d;
    end
  end

  assign rd_go    = (state_q == RD) && key_gate && !lock_act;
  assign rom_cen  = !rd_go;
  assign rom_addr = rd_go ? (base_q + cnt_q[AW-1:0]) : '0;

  assign out_v    = (state_q == OUT) && key_gate;
  assign a_valid  = out_v && (port_q == PORT_A);
  assign b_valid  = out_v && (port_q == PORT_B);

  assign a_done   = (state_q == FIN) && !err_q && (port_q == PORT_A);
  assign b_done   = (state_q == FIN) && !err_q && (port_q == PORT_B);
  assign a_err    = (state_q == FIN) && err_q && (port_q == PORT_A);
  assign b_err    = (state_q == FIN) && err_q && (port_q == PORT_B);

  assign key_data = kd_q;

endmodule

// File: tb/tb_keyrom_ctrl.sv
// Directed self-checking bench for keyrom_ctrl with a behavioural ROM.
// Lock scenarios run only when KEYROM_CTRL_LOCK_EN is defined.
module tb_keyrom_ctrl;

  logic        mclk = 1'b0;
  logic        reset_n;
  logic        key_gate;
  logic        a_req, b_req;
  logic [4:0]  a_base, b_base;
  logic [5:0]  a_len, b_len;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic        a_done, b_done;
  logic        a_err, b_err;
  logic [15:0] key_data;
  logic [4:0]  rom_addr;
  logic        rom_cen;
  logic [15:0] rom_dout;
`ifdef KEYROM_CTRL_LOCK_EN
  logic        lock_set;
  logic        locked;
`endif

  logic [15:0] mem [0:9];
  int          acc_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 mclk = ~mclk;

  always @(posedge mclk) begin
    if (!rom_cen) begin
      rom_dout <= mem[rom_addr];
      acc_cnt  <= acc_cnt + 1;
    end
  end

  keyrom_ctrl #(.ADDR_MSB(4), .MEM_SIZE(20)) dut (
    .mclk     (mclk),
    .reset_n  (reset_n),
    .key_gate (key_gate),
    .a_req    (a_req),
    .b_req    (b_req),
    .a_base   (a_base),
    .b_base   (b_base),
    .a_len    (a_len),
    .b_len    (b_len),
    .a_valid  (a_valid),
    .b_valid  (b_valid),
    .a_ready  (a_ready),
    .b_ready  (b_ready),
    .a_done   (a_done),
    .b_done   (b_done),
    .a_err    (a_err),
    .b_err    (b_err),
    .key_data (key_data),
    .rom_addr (rom_addr),
    .rom_cen  (rom_cen),
    .rom_dout (rom_dout)
`ifdef KEYROM_CTRL_LOCK_EN
    ,
    .lock_set (lock_set),
    .locked   (locked)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (2) @(negedge mclk);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_done", {a_done, b_done}, 0);
    chk("rst_err", {a_err, b_err}, 0);
    chk("rst_key_data", key_data, 0);
    chk("rst_rom_cen", rom_cen, 1);
    chk("rst_rom_addr", rom_addr, 0);
`ifdef KEYROM_CTRL_LOCK_EN
    chk("rst_locked", locked, 0);
`endif
    reset_n = 1'b1;
    @(negedge mclk);
  endtask

  // One burst on one port; cycle 1 is the CHECK cycle.
  task automatic burst(input bit p, input logic [4:0] base,
                       input logic [5:0] len, input int stall,
                       input bit chk_rd, output int nw, output bit dn,
                       output bit er, output int t_first,
                       output int t_end, output int acc,
                       output logic [15:0] kd_end);
    int a0 = acc_cnt;
    int st = stall;
    bit v;
    nw = 0; dn = 0; er = 0;
    t_first = -1; t_end = -1; kd_end = 16'hxxxx;
    a_ready = 1'b1; b_ready = 1'b1;
    if (p) begin
      b_base = base; b_len = len; b_req = 1'b1;
    end else begin
      a_base = base; a_len = len; a_req = 1'b1;
    end
    for (int c = 1; c <= 200; c++) begin
      @(negedge mclk);
      if (chk_rd && c == 2) begin
        chk("rd_cen", rom_cen, 0);
        chk("rd_addr", rom_addr, base);
      end
      v = p ? b_valid : a_valid;
      if (v && t_first < 0) t_first = c;
      if (v && st > 0) begin
        chk("stall_data", key_data, mem[base]);
        chk("stall_cen", rom_cen, 1);
        if (p) b_ready = 1'b0; else a_ready = 1'b0;
        st--;
      end else if (v) begin
        a_ready = 1'b1; b_ready = 1'b1;
        chk("word_data", key_data, mem[base + 5'(nw)]);
        nw++;
      end
      if (p ? (b_done || b_err) : (a_done || a_err)) begin
        dn = p ? b_done : a_done;
        er = p ? b_err : a_err;
        t_end = c;
        kd_end = key_data;
        a_req = 1'b0; b_req = 1'b0;
        break;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    a_ready = 1'b1; b_ready = 1'b1;
    acc = acc_cnt - a0;
    @(negedge mclk);
    chk("pulse_gone", {a_done, b_done, a_err, b_err}, 0);
  endtask

  task automatic pair(output int first, output int second, output int fv);
    first = -1; second = -1; fv = -1;
    a_base = 5'd0; a_len = 6'd2;
    b_base = 5'd4; b_len = 6'd2;
    a_req = 1'b1; b_req = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge mclk);
      if (fv < 0 && a_valid) fv = 0;
      else if (fv < 0 && b_valid) fv = 1;
      if (a_done || a_err) begin
        a_req = 1'b0;
        if (first < 0) first = 0; else second = 0;
      end
      if (b_done || b_err) begin
        b_req = 1'b0;
        if (first < 0) first = 1; else second = 1;
      end
      if (second >= 0) break;
    end
    a_req = 1'b0; b_req = 1'b0;
    @(negedge mclk);
  endtask

  int nw, tf, te, acc, first, second, fv, snap, hs;
  bit dn, er, reached;
  logic [15:0] kde;

  initial begin
    key_gate = 1'b1;
    a_ready = 1'b1; b_ready = 1'b1;
    a_base = '0; b_base = '0; a_len = '0; b_len = '0;
`ifdef KEYROM_CTRL_LOCK_EN
    lock_set = 1'b0;
`endif
    for (int i = 0; i < 10; i++) mem[i] = 16'hcccc;
    do_reset();

    burst(0, 5'd0, 6'd10, 0, 1, nw, dn, er, tf, te, acc, kde);
    chk("t1_words", nw, 10);
    chk("t1_first_valid", tf, 4);
    chk("t1_done", {dn, er}, 2'b10);
    chk("t1_done_cycle", te, 32);
    chk("t1_accesses", acc, 10);
    chk("t1_kd_clear", kde, 0);
    chk("t1_kd_after", key_data, 0);

    for (int i = 0; i < 10; i++) mem[i] = 16'h1000 + 16'(i * 16'h0111);

    burst(1, 5'd8, 6'd3, 0, 0, nw, dn, er, tf, te, acc, kde);
    chk("rej_err", {dn, er}, 2'b01);
    chk("rej_cycle", te, 2);
    chk("rej_no_access", acc, 0);

    burst(1, 5'd6, 6'd4, 0, 1, nw, dn, er, tf, te, acc, kde);
    chk("b_words", nw, 4);
    chk("b_done", {dn, er}, 2'b10);
    chk("b_done_cycle", te, 14);
    chk("b_accesses", acc, 4);

    burst(0, 5'd2, 6'd2, 5, 0, nw, dn, er, tf, te, acc, kde);
    chk("stall_words", nw, 2);
    chk("stall_done", {dn, er}, 2'b10);
    chk("stall_done_cycle", te, 13);
    chk("stall_accesses", acc, 2);

    burst(0, 5'd5, 6'd0, 0, 0, nw, dn, er, tf, te, acc, kde);
    chk("len0_done", {dn, er}, 2'b10);
    chk("len0_cycle", te, 2);
    chk("len0_no_access", acc, 0);

    snap = acc_cnt; hs = 0; reached = 0;
    a_base = 5'd3; a_len = 6'd4; a_req = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge mclk);
      if (a_valid) begin
        if (hs == 1) begin
          reached = 1;
          chk("gate_w1", key_data, mem[4]);
          key_gate = 1'b0;
          #1;
          chk("gate_vdrop", a_valid, 0);
          @(negedge mclk);
          chk("gate_err", a_err, 1);
          chk("gate_kd", key_data, 0);
          chk("gate_valid", a_valid, 0);
          break;
        end
        hs++;
      end
    end
    a_req = 1'b0;
    key_gate = 1'b1;
    repeat (3) @(negedge mclk);
    chk("gate_reach", reached, 1);
    chk("gate_accesses", acc_cnt - snap, 2);

    do_reset();
    pair(first, second, fv);
    chk("pair1_first", first, 0);
    chk("pair1_second", second, 1);
    chk("pair1_first_valid", fv, 0);
    burst(0, 5'd0, 6'd1, 0, 0, nw, dn, er, tf, te, acc, kde);
    chk("solo_done", {dn, er}, 2'b10);
    pair(first, second, fv);
    chk("pair2_first", first, 1);
    chk("pair2_second", second, 0);
    chk("pair2_first_valid", fv, 1);

`ifdef KEYROM_CTRL_LOCK_EN
    snap = acc_cnt; reached = 0; er = 0;
    a_base = 5'd0; a_len = 6'd3; a_req = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge mclk);
      if (a_valid && !reached) begin
        reached = 1;
        lock_set = 1'b1;
        @(negedge mclk);
        lock_set = 1'b0;
      end
      if (a_err || a_done) begin
        er = a_err;
        break;
      end
    end
    a_req = 1'b0;
    chk("lock_abort_err", er, 1);
    chk("lock_locked", locked, 1);
    chk("lock_accesses", acc_cnt - snap, 1);
    @(negedge mclk);
    burst(1, 5'd0, 6'd1, 0, 0, nw, dn, er, tf, te, acc, kde);
    chk("lock_new_err", {dn, er}, 2'b01);
    chk("lock_new_cycle", te, 2);
    chk("lock_new_acc", acc, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("lock_async_clear", locked, 0);
    @(negedge mclk);
    reset_n = 1'b1;
    @(negedge mclk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
